// File: rtl/fp_serial_frontend_pkg.sv
// Shared widths, FSM state type and byte-insert helper for the fp_addsub serial frontend.
package fp_serial_frontend_pkg;

  localparam int unsigned FP_W                = 32;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned FRAME_OPERAND_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CALC   = 3'd3,
    ST_SEND   = 3'd4
  } state_e;

  function automatic logic [FP_W-1:0] put_byte(input logic [FP_W-1:0]   word,
                                               input logic [1:0]        idx,
                                               input logic [BYTE_W-1:0] b);
    logic [FP_W-1:0] w;
    w = word;
    w[BYTE_W*idx +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/fp_result_serializer.sv
// Holds the captured fp_addsub result and streams it out LSB byte first over valid/ready.
module fp_result_serializer
  import fp_serial_frontend_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [FP_W-1:0]   res_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              done_o
);

  logic [FP_W-1:0] res_q, res_d;
  logic [1:0]      k_q, k_d;
  logic            valid_q, valid_d;
  logic            last_byte;
  logic            xfer;

  assign last_byte = (k_q == 2'(FRAME_OPERAND_BYTES - 1));
  assign xfer      = valid_q & out_ready_i;

  always_comb begin
    res_d   = res_q;
    k_d     = k_q;
    valid_d = valid_q;
    if (load_i) begin
      res_d   = res_i;
      k_d     = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      k_d = k_q + 2'd1;
      if (last_byte) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  // Byte lane is forced to zero outside SEND so an idle stream never shows stale result bits.
  assign out_valid_o = valid_q;
  assign out_data_o  = valid_q ? res_q[BYTE_W*k_q +: BYTE_W] : '0;
  assign out_last_o  = valid_q & last_byte;
  assign done_o      = xfer & last_byte;

endmodule

// File: rtl/fp_serial_frontend.sv
// Byte-serial command frontend for fp_addsub: assembles cmd/A/B, commits operands, returns 4 result bytes.
module fp_serial_frontend
  import fp_serial_frontend_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [FP_W-1:0]   op_a,
  output logic [FP_W-1:0]   op_b,
  output logic              op_sub,
  input  logic [FP_W-1:0]   res_in,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout
);

  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0]      IDX_LAST = 2'(FRAME_OPERAND_BYTES - 1);

  state_e           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [FP_W-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic             sh_sub_q, sh_sub_d;
  logic [FP_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_sub_q, op_sub_d;
  logic             err_q, err_d;
  logic             accept;
  logic             ser_load;
  logic             ser_done;

  assign in_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD_A) | (state_q == ST_LOAD_B));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    idle_cnt_d = '0;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_sub_d   = sh_sub_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sub_d   = op_sub_q;
    err_d      = 1'b0;
    ser_load   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_sub_d   = in_data[0];
          byte_idx_d = '0;
          state_d    = ST_LOAD_A;
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (state_q == ST_LOAD_A) sh_a_d = put_byte(sh_a_q, byte_idx_q, in_data);
          else                      sh_b_d = put_byte(sh_b_q, byte_idx_q, in_data);
          if (byte_idx_q == IDX_LAST) begin
            if (state_q == ST_LOAD_A) begin
              state_d = ST_LOAD_B;
            end else begin
              // Commit uses the shadow's next value so the final B byte lands in op_b on this edge.
              state_d  = ST_CALC;
              op_a_d   = sh_a_q;
              op_b_d   = sh_b_d;
              op_sub_d = sh_sub_q;
            end
          end
        end else if (TO_EN && idle_cnt_q == LIMIT_M1) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          byte_idx_d = '0;
          sh_a_d     = '0;
          sh_b_d     = '0;
          sh_sub_d   = 1'b0;
        end else if (TO_EN) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      ST_CALC: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      idle_cnt_q <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_sub_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      idle_cnt_q <= idle_cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_sub_q   <= sh_sub_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      err_q      <= err_d;
    end
  end

  fp_result_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .res_i       (res_in),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (ser_done)
  );

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_sub      = op_sub_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule
